// File: rtl/uart_cfg.sv
// Full-duplex UART with configurable data width, parity mode and stop-bit count.
// Independent TX and RX engines; the RX input is synchronised and the start bit is glitch-filtered.
`timescale 1ns/1ps
module uart_cfg #(
  parameter int unsigned CLOCK_DIVIDE = 2604,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 transmit,
  input  logic [DATA_BITS-1:0] tx_byte,
  output logic                 received,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 is_receiving,
  output logic                 is_transmitting,
  output logic                 recv_error,
  output logic                 parity_error,
  output logic                 frame_error
);

  localparam int unsigned CNT_W = $clog2(CLOCK_DIVIDE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCK_DIVIDE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCK_DIVIDE / 2 - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  // Parity bit value that accompanies a payload: odd = ~^data, even = ^data.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
    return (PARITY == 1) ? ~^data : ^data;
  endfunction

  // ---------------------------------------------------------------- transmitter
  state_t               r_tx_state;
  logic [CNT_W-1:0]     r_tx_cnt;
  logic [IDX_W-1:0]     r_tx_idx;
  logic [DATA_BITS-1:0] r_tx_data;
  logic [DATA_BITS-1:0] r_tx_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state      <= S_IDLE;
      r_tx_cnt        <= '0;
      r_tx_idx        <= '0;
      r_tx_data       <= '0;
      r_tx_shift      <= '0;
      tx              <= 1'b1;
      is_transmitting <= 1'b0;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          if (transmit) begin
            r_tx_data       <= tx_byte;
            r_tx_shift      <= tx_byte;
            r_tx_cnt        <= '0;
            r_tx_idx        <= '0;
            tx              <= 1'b0;
            is_transmitting <= 1'b1;
            r_tx_state      <= S_START;
          end
        end
        S_START: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt   <= '0;
            tx         <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
            r_tx_state <= S_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == DATA_LAST) begin
              r_tx_idx <= '0;
              if (HAS_PARITY) begin
                tx         <= parity_of(r_tx_data);
                r_tx_state <= S_PARITY;
              end else begin
                tx         <= 1'b1;
                r_tx_state <= S_STOP;
              end
            end else begin
              r_tx_idx   <= r_tx_idx + IDX_W'(1);
              tx         <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt   <= '0;
            tx         <= 1'b1;
            r_tx_state <= S_STOP;
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          // r_tx_idx counts stop bits here; the last one returns to IDLE.
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == STOP_LAST) begin
              r_tx_idx        <= '0;
              is_transmitting <= 1'b0;
              r_tx_state      <= S_IDLE;
            end else begin
              r_tx_idx <= r_tx_idx + IDX_W'(1);
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        default: begin
          tx              <= 1'b1;
          is_transmitting <= 1'b0;
          r_tx_state      <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- receiver
  logic r_rx_meta;
  logic r_rx_sync;
  logic w_rxs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_rxs = r_rx_sync;

  state_t               r_rx_state;
  logic [CNT_W-1:0]     r_rx_cnt;
  logic [IDX_W-1:0]     r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par_bad;
  logic                 r_rx_stop;
  logic                 r_rx_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state   <= S_IDLE;
      r_rx_cnt     <= '0;
      r_rx_idx     <= '0;
      r_rx_shift   <= '0;
      r_rx_par_bad <= 1'b0;
      r_rx_stop    <= 1'b1;
      r_rx_done    <= 1'b0;
      rx_byte      <= '0;
      received     <= 1'b0;
      recv_error   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      is_receiving <= 1'b0;
    end else begin
      received     <= 1'b0;
      recv_error   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      r_rx_done    <= 1'b0;

      // Frame verdict lands one cycle after the stop-bit sample.
      if (r_rx_done) begin
        if (r_rx_stop && !r_rx_par_bad) begin
          rx_byte      <= r_rx_shift;
          received     <= 1'b1;
          is_receiving <= 1'b0;
        end else begin
          recv_error   <= 1'b1;
          parity_error <= r_rx_par_bad;
          frame_error  <= ~r_rx_stop;
          if (r_rx_stop) begin
            is_receiving <= 1'b0;
          end
        end
      end

      case (r_rx_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_START;
          end
        end
        S_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt <= '0;
            if (w_rxs) begin
              r_rx_state <= S_IDLE;
            end else begin
              r_rx_idx     <= '0;
              r_rx_par_bad <= 1'b0;
              is_receiving <= 1'b1;
              r_rx_state   <= S_DATA;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rxs, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_idx == DATA_LAST) begin
              r_rx_idx   <= '0;
              r_rx_state <= HAS_PARITY ? S_PARITY : S_STOP;
            end else begin
              r_rx_idx <= r_rx_idx + IDX_W'(1);
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt     <= '0;
            r_rx_par_bad <= (w_rxs != parity_of(r_rx_shift));
            r_rx_state   <= S_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_stop  <= w_rxs;
            r_rx_done  <= 1'b1;
            r_rx_state <= w_rxs ? S_IDLE : S_BREAK;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        S_BREAK: begin
          // Line held low past the stop bit: wait for it to return high.
          if (w_rxs) begin
            is_receiving <= 1'b0;
            r_rx_state   <= S_IDLE;
          end
        end
        default: begin
          r_rx_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cfg.sv
// Directed self-checking bench for uart_cfg: cross-connected pairs plus bench-driven receivers.
`timescale 1ns/1ps
module tb_uart_cfg;

  localparam int unsigned CD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  // u_a <-> u_b : 8N1 pair; u_b's rx can be taken over by the bench.
  logic       a_tx, a_transmit, a_received, a_is_rx, a_is_tx, a_rerr, a_perr, a_ferr;
  logic [7:0] a_tx_byte, a_rx_byte;
  logic       b_tx, b_rx, b_received, b_is_rx, b_is_tx, b_rerr, b_perr, b_ferr;
  logic [7:0] b_rx_byte;
  logic       b_rx_sel, b_rx_drv;
  assign b_rx = b_rx_sel ? b_rx_drv : a_tx;

  // u_c <-> u_d : even parity pair; u_e : even parity, two stop bits; u_f : odd parity RX.
  logic       c_tx, c_transmit, c_received, c_is_rx, c_is_tx, c_rerr, c_perr, c_ferr;
  logic [7:0] c_tx_byte, c_rx_byte;
  logic       d_tx, d_received, d_is_rx, d_is_tx, d_rerr, d_perr, d_ferr;
  logic [7:0] d_rx_byte;
  logic       e_tx, e_transmit, e_received, e_is_rx, e_is_tx, e_rerr, e_perr, e_ferr;
  logic [7:0] e_tx_byte, e_rx_byte;
  logic       f_tx, f_received, f_is_rx, f_is_tx, f_rerr, f_perr, f_ferr, f_rx_drv;
  logic [7:0] f_rx_byte;

  uart_cfg #(.CLOCK_DIVIDE(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .rx(b_tx), .tx(a_tx), .transmit(a_transmit), .tx_byte(a_tx_byte),
    .received(a_received), .rx_byte(a_rx_byte), .is_receiving(a_is_rx), .is_transmitting(a_is_tx),
    .recv_error(a_rerr), .parity_error(a_perr), .frame_error(a_ferr));

  uart_cfg #(.CLOCK_DIVIDE(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .rx(b_rx), .tx(b_tx), .transmit(1'b0), .tx_byte(8'h00),
    .received(b_received), .rx_byte(b_rx_byte), .is_receiving(b_is_rx), .is_transmitting(b_is_tx),
    .recv_error(b_rerr), .parity_error(b_perr), .frame_error(b_ferr));

  uart_cfg #(.CLOCK_DIVIDE(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_c (
    .clk(clk), .rst(rst), .rx(d_tx), .tx(c_tx), .transmit(c_transmit), .tx_byte(c_tx_byte),
    .received(c_received), .rx_byte(c_rx_byte), .is_receiving(c_is_rx), .is_transmitting(c_is_tx),
    .recv_error(c_rerr), .parity_error(c_perr), .frame_error(c_ferr));

  uart_cfg #(.CLOCK_DIVIDE(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_d (
    .clk(clk), .rst(rst), .rx(c_tx), .tx(d_tx), .transmit(1'b0), .tx_byte(8'h00),
    .received(d_received), .rx_byte(d_rx_byte), .is_receiving(d_is_rx), .is_transmitting(d_is_tx),
    .recv_error(d_rerr), .parity_error(d_perr), .frame_error(d_ferr));

  uart_cfg #(.CLOCK_DIVIDE(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_e (
    .clk(clk), .rst(rst), .rx(1'b1), .tx(e_tx), .transmit(e_transmit), .tx_byte(e_tx_byte),
    .received(e_received), .rx_byte(e_rx_byte), .is_receiving(e_is_rx), .is_transmitting(e_is_tx),
    .recv_error(e_rerr), .parity_error(e_perr), .frame_error(e_ferr));

  uart_cfg #(.CLOCK_DIVIDE(CD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_f (
    .clk(clk), .rst(rst), .rx(f_rx_drv), .tx(f_tx), .transmit(1'b0), .tx_byte(8'h00),
    .received(f_received), .rx_byte(f_rx_byte), .is_receiving(f_is_rx), .is_transmitting(f_is_tx),
    .recv_error(f_rerr), .parity_error(f_perr), .frame_error(f_ferr));

  // Cycle-high counters for the pulse outputs (a one-cycle pulse adds exactly 1).
  int b_n_rcv = 0, b_n_rerr = 0, b_n_perr = 0, b_n_ferr = 0, b_n_busy = 0;
  int d_n_rcv = 0, d_n_rerr = 0;
  int f_n_rcv = 0, f_n_rerr = 0, f_n_perr = 0, f_n_ferr = 0;

  always @(negedge clk) begin
    b_n_rcv  <= b_n_rcv  + int'(b_received);
    b_n_rerr <= b_n_rerr + int'(b_rerr);
    b_n_perr <= b_n_perr + int'(b_perr);
    b_n_ferr <= b_n_ferr + int'(b_ferr);
    b_n_busy <= b_n_busy + int'(b_is_rx);
    d_n_rcv  <= d_n_rcv  + int'(d_received);
    d_n_rerr <= d_n_rerr + int'(d_rerr);
    f_n_rcv  <= f_n_rcv  + int'(f_received);
    f_n_rerr <= f_n_rerr + int'(f_rerr);
    f_n_perr <= f_n_perr + int'(f_perr);
    f_n_ferr <= f_n_ferr + int'(f_ferr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a bit sequence (LSB first, CD cycles per bit) onto u_b (which=0) or u_f (which=1).
  task automatic drive_rx(input int which, input logic [11:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (which == 0) b_rx_drv = bits[i];
      else            f_rx_drv = bits[i];
      repeat (CD) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_vec++; if (a_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b expected 1", a_tx); end
    n_vec++; if (a_is_tx !== 1'b0) begin n_bad++; $display("FAIL reset_is_tx: got %b expected 0", a_is_tx); end
    n_vec++; if (b_rx_byte !== 8'h00) begin n_bad++; $display("FAIL reset_rx_byte: got %h expected 00", b_rx_byte); end
    n_vec++; if (b_received !== 1'b0) begin n_bad++; $display("FAIL reset_received: got %b expected 0", b_received); end
    n_vec++; if (b_is_rx !== 1'b0) begin n_bad++; $display("FAIL reset_is_rx: got %b expected 0", b_is_rx); end
    n_vec++; if ({b_rerr, b_perr, b_ferr} !== 3'b000) begin
      n_bad++; $display("FAIL reset_errors: got %b expected 000", {b_rerr, b_perr, b_ferr});
    end
    rst = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_8n1();
    int          rcv0 = b_n_rcv;
    int          err0 = b_n_rerr + b_n_perr + b_n_ferr;
    logic [9:0]  fr   = {1'b1, 8'hA5, 1'b0};
    logic        exp_tx;
    a_tx_byte  = 8'hA5;
    a_transmit = 1'b1;
    tick();
    a_transmit = 1'b0;
    for (int k = 0; k <= 160; k++) begin
      exp_tx = (k < 160) ? fr[k / CD] : 1'b1;
      n_vec++; if (a_tx !== exp_tx) begin n_bad++; $display("FAIL 8n1_tx cyc %0d: got %b expected %b", k, a_tx, exp_tx); end
      n_vec++; if (a_is_tx !== (k < 160)) begin
        n_bad++; $display("FAIL 8n1_is_tx cyc %0d: got %b expected %b", k, a_is_tx, (k < 160));
      end
      tick();
    end
    repeat (20) tick();
    n_vec++; if (b_n_rcv - rcv0 !== 1) begin n_bad++; $display("FAIL 8n1_received: got %0d pulses expected 1", b_n_rcv - rcv0); end
    n_vec++; if (b_rx_byte !== 8'hA5) begin n_bad++; $display("FAIL 8n1_rx_byte: got %h expected a5", b_rx_byte); end
    n_vec++; if (b_n_rerr + b_n_perr + b_n_ferr - err0 !== 0) begin
      n_bad++; $display("FAIL 8n1_errors: got %0d expected 0", b_n_rerr + b_n_perr + b_n_ferr - err0);
    end
  endtask

  task automatic test_even_parity();
    int          rcv0 = d_n_rcv;
    int          err0 = d_n_rerr;
    logic [10:0] fc   = {1'b1, 1'b1, 8'h07, 1'b0};
    logic [11:0] fe   = {1'b1, 1'b1, 1'b1, 8'h07, 1'b0};
    logic        exp_c, exp_e;
    c_tx_byte  = 8'h07;
    e_tx_byte  = 8'h07;
    c_transmit = 1'b1;
    e_transmit = 1'b1;
    tick();
    c_transmit = 1'b0;
    e_transmit = 1'b0;
    for (int k = 0; k <= 193; k++) begin
      exp_c = (k < 176) ? fc[k / CD] : 1'b1;
      exp_e = (k < 192) ? fe[k / CD] : 1'b1;
      n_vec++; if (c_tx !== exp_c) begin n_bad++; $display("FAIL par_tx cyc %0d: got %b expected %b", k, c_tx, exp_c); end
      n_vec++; if (c_is_tx !== (k < 176)) begin
        n_bad++; $display("FAIL par_is_tx cyc %0d: got %b expected %b", k, c_is_tx, (k < 176));
      end
      n_vec++; if (e_tx !== exp_e) begin n_bad++; $display("FAIL stop2_tx cyc %0d: got %b expected %b", k, e_tx, exp_e); end
      n_vec++; if (e_is_tx !== (k < 192)) begin
        n_bad++; $display("FAIL stop2_is_tx cyc %0d: got %b expected %b", k, e_is_tx, (k < 192));
      end
      tick();
    end
    repeat (10) tick();
    n_vec++; if (d_rx_byte !== 8'h07) begin n_bad++; $display("FAIL par_rx_byte: got %h expected 07", d_rx_byte); end
    n_vec++; if (d_n_rcv - rcv0 !== 1) begin n_bad++; $display("FAIL par_received: got %0d expected 1", d_n_rcv - rcv0); end
    n_vec++; if (d_n_rerr - err0 !== 0) begin n_bad++; $display("FAIL par_errors: got %0d expected 0", d_n_rerr - err0); end
  endtask

  task automatic test_parity_error();
    int rcv0 = f_n_rcv;
    int rerr0 = f_n_rerr;
    int perr0 = f_n_perr;
    int ferr0 = f_n_ferr;
    // 0x5A has four ones: odd parity bit is 1 (good frame).
    drive_rx(1, {1'b0, 1'b1, 1'b1, 8'h5A, 1'b0}, 11);
    f_rx_drv = 1'b1;
    repeat (20) tick();
    n_vec++; if (f_rx_byte !== 8'h5A) begin n_bad++; $display("FAIL odd_good_rx_byte: got %h expected 5a", f_rx_byte); end
    n_vec++; if (f_n_rcv - rcv0 !== 1) begin n_bad++; $display("FAIL odd_good_received: got %0d expected 1", f_n_rcv - rcv0); end
    n_vec++; if (f_n_rerr - rerr0 !== 0) begin n_bad++; $display("FAIL odd_good_error: got %0d expected 0", f_n_rerr - rerr0); end
    // 0x07 has three ones: odd parity bit should be 0, send 1.
    drive_rx(1, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    f_rx_drv = 1'b1;
    repeat (20) tick();
    n_vec++; if (f_rx_byte !== 8'h5A) begin n_bad++; $display("FAIL odd_bad_rx_byte: got %h expected 5a", f_rx_byte); end
    n_vec++; if (f_n_rcv - rcv0 !== 1) begin n_bad++; $display("FAIL odd_bad_received: got %0d expected 1", f_n_rcv - rcv0); end
    n_vec++; if (f_n_rerr - rerr0 !== 1) begin n_bad++; $display("FAIL odd_bad_recv_error: got %0d expected 1", f_n_rerr - rerr0); end
    n_vec++; if (f_n_perr - perr0 !== 1) begin n_bad++; $display("FAIL odd_bad_parity_error: got %0d expected 1", f_n_perr - perr0); end
    n_vec++; if (f_n_ferr - ferr0 !== 0) begin n_bad++; $display("FAIL odd_bad_frame_error: got %0d expected 0", f_n_ferr - ferr0); end
  endtask

  task automatic test_frame_error();
    int rcv0 = b_n_rcv;
    int rerr0 = b_n_rerr;
    int perr0 = b_n_perr;
    int ferr0 = b_n_ferr;
    b_rx_drv = 1'b1;
    b_rx_sel = 1'b1;
    repeat (5) tick();
    drive_rx(0, {2'b00, 1'b0, 8'h3C, 1'b0}, 10);
    for (int h = 0; h < 100; h++) begin
      tick();
      if (h >= 19 && (h % 10) == 9) begin
        n_vec++; if (b_is_rx !== 1'b1) begin n_bad++; $display("FAIL break_is_rx cyc %0d: got %b expected 1", h, b_is_rx); end
      end
    end
    n_vec++; if (b_n_rerr - rerr0 !== 1) begin n_bad++; $display("FAIL frm_recv_error: got %0d expected 1", b_n_rerr - rerr0); end
    n_vec++; if (b_n_ferr - ferr0 !== 1) begin n_bad++; $display("FAIL frm_frame_error: got %0d expected 1", b_n_ferr - ferr0); end
    n_vec++; if (b_n_perr - perr0 !== 0) begin n_bad++; $display("FAIL frm_parity_error: got %0d expected 0", b_n_perr - perr0); end
    n_vec++; if (b_n_rcv - rcv0 !== 0) begin n_bad++; $display("FAIL frm_received: got %0d expected 0", b_n_rcv - rcv0); end
    n_vec++; if (b_rx_byte !== 8'hA5) begin n_bad++; $display("FAIL frm_rx_byte: got %h expected a5", b_rx_byte); end
    b_rx_drv = 1'b1;
    repeat (20) tick();
    n_vec++; if (b_is_rx !== 1'b0) begin n_bad++; $display("FAIL break_exit_is_rx: got %b expected 0", b_is_rx); end
    drive_rx(0, {2'b00, 1'b1, 8'h55, 1'b0}, 10);
    b_rx_drv = 1'b1;
    repeat (20) tick();
    n_vec++; if (b_rx_byte !== 8'h55) begin n_bad++; $display("FAIL after_break_rx_byte: got %h expected 55", b_rx_byte); end
    n_vec++; if (b_n_rcv - rcv0 !== 1) begin n_bad++; $display("FAIL after_break_received: got %0d expected 1", b_n_rcv - rcv0); end
    n_vec++; if (b_n_rerr - rerr0 !== 1) begin n_bad++; $display("FAIL after_break_errors: got %0d expected 1", b_n_rerr - rerr0); end
  endtask

  task automatic test_glitch();
    int rcv0 = b_n_rcv;
    int err0 = b_n_rerr + b_n_perr + b_n_ferr;
    int busy0 = b_n_busy;
    b_rx_drv = 1'b0;
    repeat (5) tick();
    b_rx_drv = 1'b1;
    repeat (40) tick();
    n_vec++; if (b_n_rcv - rcv0 !== 0) begin n_bad++; $display("FAIL glitch_received: got %0d expected 0", b_n_rcv - rcv0); end
    n_vec++; if (b_n_rerr + b_n_perr + b_n_ferr - err0 !== 0) begin
      n_bad++; $display("FAIL glitch_errors: got %0d expected 0", b_n_rerr + b_n_perr + b_n_ferr - err0);
    end
    n_vec++; if (b_n_busy - busy0 !== 0) begin n_bad++; $display("FAIL glitch_is_rx: got %0d cycles expected 0", b_n_busy - busy0); end
    n_vec++; if (b_rx_byte !== 8'h55) begin n_bad++; $display("FAIL glitch_rx_byte: got %h expected 55", b_rx_byte); end
    b_rx_sel = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset_mid_frame();
    int rcv0 = b_n_rcv;
    a_tx_byte  = 8'hFF;
    a_transmit = 1'b1;
    tick();
    a_transmit = 1'b0;
    repeat (4 * CD + 7) tick();
    n_vec++; if (a_is_tx !== 1'b1) begin n_bad++; $display("FAIL pre_reset_is_tx: got %b expected 1", a_is_tx); end
    rst = 1'b1;
    tick();
    n_vec++; if (a_tx !== 1'b1) begin n_bad++; $display("FAIL midrst_tx: got %b expected 1", a_tx); end
    n_vec++; if (a_is_tx !== 1'b0) begin n_bad++; $display("FAIL midrst_is_tx: got %b expected 0", a_is_tx); end
    n_vec++; if (b_is_rx !== 1'b0) begin n_bad++; $display("FAIL midrst_peer_is_rx: got %b expected 0", b_is_rx); end
    rst = 1'b0;
    repeat (200) tick();
    n_vec++; if (b_n_rcv - rcv0 !== 0) begin n_bad++; $display("FAIL midrst_peer_received: got %0d expected 0", b_n_rcv - rcv0); end
    n_vec++; if (b_rx_byte !== 8'h00) begin n_bad++; $display("FAIL midrst_peer_rx_byte: got %h expected 00", b_rx_byte); end
    a_tx_byte  = 8'h81;
    a_transmit = 1'b1;
    tick();
    a_transmit = 1'b0;
    repeat (190) tick();
    n_vec++; if (b_rx_byte !== 8'h81) begin n_bad++; $display("FAIL postrst_rx_byte: got %h expected 81", b_rx_byte); end
    n_vec++; if (b_n_rcv - rcv0 !== 1) begin n_bad++; $display("FAIL postrst_received: got %0d expected 1", b_n_rcv - rcv0); end
  endtask

  initial begin
    rst        = 1'b1;
    a_transmit = 1'b0;
    c_transmit = 1'b0;
    e_transmit = 1'b0;
    a_tx_byte  = 8'h00;
    c_tx_byte  = 8'h00;
    e_tx_byte  = 8'h00;
    b_rx_sel   = 1'b0;
    b_rx_drv   = 1'b1;
    f_rx_drv   = 1'b1;
    test_reset();
    test_8n1();
    test_even_parity();
    test_parity_error();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
